// File: rtl/fwrisc_prefetch.sv
// Instruction prefetch queue: runs sequential word fetches ahead of the core into
// a DEPTH-entry FIFO and restarts cleanly on branch/trap redirects.
module fwrisc_prefetch #(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      resvec,
    output logic [31:0]      iaddr,
    output logic             ivalid,
    input  logic             iready,
    input  logic [31:0]      idata,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic             fetch_valid,
    output logic [31:0]      fetch_addr,
    output logic [31:0]      fetch_data,
    input  logic             fetch_ready,
    output logic [CNT_W-1:0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {BOOT, IDLE, REQ, DRAIN} state_t;

    state_t           state;
    logic [31:0]      fetch_ptr;
    logic [31:0]      iaddr_reg;
    logic             ivalid_reg;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [31:0]      addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];

    logic flush;
    logic push;
    logic pop;
    logic has_room;

    assign flush    = redirect && (state != BOOT);
    assign push     = (state == REQ) && iready && !flush;
    assign pop      = (count != '0) && fetch_ready && !flush;
    assign has_room = count_next < FULL;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (!push && pop) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= BOOT;
            fetch_ptr  <= '0;
            iaddr_reg  <= '0;
            ivalid_reg <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count_next;
            end

            case (state)
                BOOT: begin
                    fetch_ptr  <= resvec & WORD_MASK;
                    iaddr_reg  <= resvec & WORD_MASK;
                    ivalid_reg <= 1'b0;
                    state      <= IDLE;
                end
                IDLE: begin
                    if (flush) begin
                        fetch_ptr  <= redirect_pc & WORD_MASK;
                        iaddr_reg  <= redirect_pc & WORD_MASK;
                        ivalid_reg <= 1'b1;
                        state      <= REQ;
                    end else if (has_room) begin
                        iaddr_reg  <= fetch_ptr;
                        ivalid_reg <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (flush) begin
                        fetch_ptr <= redirect_pc & WORD_MASK;
                        if (iready) begin
                            iaddr_reg <= redirect_pc & WORD_MASK;
                        end else begin
                            // Outstanding bus cycle must complete at the old address.
                            state <= DRAIN;
                        end
                    end else if (iready) begin
                        fetch_ptr <= fetch_ptr + 32'd4;
                        iaddr_reg <= fetch_ptr + 32'd4;
                        if (!has_room) begin
                            ivalid_reg <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (flush) fetch_ptr <= redirect_pc & WORD_MASK;
                    if (iready) begin
                        iaddr_reg <= flush ? (redirect_pc & WORD_MASK) : fetch_ptr;
                        state     <= REQ;
                    end
                end
                default: begin
                    ivalid_reg <= 1'b0;
                    state      <= BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            addr_mem[wr_ptr] <= iaddr_reg;
            data_mem[wr_ptr] <= idata;
        end
    end

    assign iaddr       = iaddr_reg;
    assign ivalid      = ivalid_reg;
    assign occupancy   = count;
    assign fetch_valid = (count != '0);
    // Gate the head with fetch_valid so an empty queue presents zeros, never stale RAM.
    assign fetch_addr  = fetch_valid ? addr_mem[rd_ptr] : '0;
    assign fetch_data  = fetch_valid ? data_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_fwrisc_prefetch.sv
// Bench for fwrisc_prefetch: directed scenarios plus random traffic, checked against
// a queue-based model of the fetch stream and bus handshake.
module tb_fwrisc_prefetch;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] resvec;
    logic [31:0] iaddr;
    logic        ivalid;
    logic        iready;
    logic [31:0] idata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_valid;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_data;
    logic        fetch_ready;
    logic [2:0]  occupancy;

    int checks = 0;
    int errors = 0;

    logic [63:0] q[$];
    logic [31:0] bus_next;
    logic [31:0] prev_iaddr;
    bit          draining;
    bit          exp_req;
    bit          prev_hold;
    int          pops = 0;

    fwrisc_prefetch #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .resvec(resvec),
        .iaddr(iaddr), .ivalid(ivalid), .iready(iready), .idata(idata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
        .fetch_ready(fetch_ready), .occupancy(occupancy)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    // Zero-wait-state memory: read data is a fixed function of the address.
    assign idata = word_at(iaddr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset(input logic [31:0] rv);
        q.delete();
        bus_next  = rv & 32'hFFFF_FFFC;
        draining  = 1'b0;
        exp_req   = 1'b0;
        prev_hold = 1'b0;
    endtask

    // One clock: compare outputs to the model at the falling edge, then advance the
    // model by what the upcoming rising edge does with the current inputs.
    task automatic step();
        logic [63:0] head;
        bit beat;
        @(negedge clock);
        check("occupancy", occupancy, q.size());
        check("fetch_valid", fetch_valid, q.size() != 0);
        if (q.size() != 0) begin
            head = q[0];
            check("head_addr", fetch_addr, head[63:32]);
            check("head_data", fetch_data, head[31:0]);
        end
        if (q.size() == DEPTH) check("full_no_req", ivalid, 0);
        if (prev_hold) begin
            check("hold_valid", ivalid, 1);
            check("hold_addr", iaddr, prev_iaddr);
        end
        if (exp_req) check("redirect_lat", ivalid, 1);
        if (ivalid && !draining) check("bus_addr", iaddr, bus_next);

        beat       = ivalid && iready;
        prev_hold  = ivalid && !iready;
        prev_iaddr = iaddr;
        exp_req    = redirect && (!ivalid || iready);
        if (redirect) begin
            q.delete();
            bus_next = redirect_pc & 32'hFFFF_FFFC;
            if (beat) draining = 1'b0;
            else if (ivalid) draining = 1'b1;
            $display("redirect pc=%h", redirect_pc);
        end else begin
            if (q.size() != 0 && fetch_ready) begin
                head = q.pop_front();
                pops++;
                $display("pop addr=%h data=%h left=%0d", head[63:32], head[31:0], q.size());
            end
            if (beat) begin
                if (draining) begin
                    draining = 1'b0;
                end else begin
                    q.push_back({iaddr, idata});
                    bus_next += 32'd4;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        resvec      = 32'h8000_0000;
        iready      = 1'b0;
        fetch_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        #2;
        check("rst_ivalid", ivalid, 0);
        check("rst_iaddr", iaddr, 0);
        check("rst_fvalid", fetch_valid, 0);
        check("rst_faddr", fetch_addr, 0);
        check("rst_fdata", fetch_data, 0);
        check("rst_occ", occupancy, 0);

        // Fill with the core stalled.
        @(posedge clock);
        #1;
        reset  = 1'b0;
        iready = 1'b1;
        model_reset(resvec);
        repeat (8) step();
        check("fill_occ", occupancy, 4);
        check("fill_ivalid", ivalid, 0);
        check("fill_head", fetch_addr, 32'h8000_0000);

        // Streaming: one word per cycle, no gaps.
        fetch_ready = 1'b1;
        repeat (12) begin
            step();
            check("stream_valid", fetch_valid, 1);
            check("stream_occ_ge3", occupancy >= 3, 1);
        end

        // Redirect to 0x100, then redirect to 0x203 while the bus stalls.
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0; iready = 1'b0; fetch_ready = 1'b0;
        check("req100_valid", ivalid, 1);
        check("req100_addr", iaddr, 32'h100);
        check("req100_occ", occupancy, 0);
        redirect = 1'b1; redirect_pc = 32'h203;
        step();
        redirect = 1'b0;
        repeat (3) begin
            step();
            check("drain_addr", iaddr, 32'h100);
            check("drain_valid", ivalid, 1);
        end
        iready = 1'b1;
        step();
        check("post_drain_addr", iaddr, 32'h200);
        check("post_drain_occ", occupancy, 0);
        step();
        check("post_drain_head", fetch_addr, 32'h200);

        // Redirect coincident with bus completion and a pop.
        redirect = 1'b1; redirect_pc = 32'h400; fetch_ready = 1'b1;
        step();
        redirect = 1'b0;
        check("coinc_occ", occupancy, 0);
        check("coinc_fvalid", fetch_valid, 0);
        check("coinc_iaddr", iaddr, 32'h400);
        check("coinc_ivalid", ivalid, 1);

        // Address wrap at the top of memory.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF9;
        step();
        redirect = 1'b0;
        check("wrap_a", iaddr, 32'hFFFF_FFF8);
        step();
        check("wrap_b", iaddr, 32'hFFFF_FFFC);
        step();
        check("wrap_c", iaddr, 32'h0000_0000);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            iready      = ($urandom_range(0, 9) < 7);
            fetch_ready = ($urandom_range(0, 9) < 6);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : 32'($urandom);
            step();
        end
        redirect = 1'b0;
        check("progress", pops > 100, 1);

        // Asynchronous reset in the middle of a bus request.
        fetch_ready = 1'b0; iready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h500;
        step();
        redirect = 1'b0;
        step();
        step();
        iready = 1'b0;
        step();
        check("pre_rst_occ", occupancy, 2);
        check("pre_rst_ivalid", ivalid, 1);
        resvec = 32'h0000_1000;
        #2 reset = 1'b1;
        #1;
        check("async_ivalid", ivalid, 0);
        check("async_fvalid", fetch_valid, 0);
        check("async_occ", occupancy, 0);
        model_reset(resvec);
        @(posedge clock);
        #1;
        reset = 1'b0;
        iready = 1'b1;
        n = 0;
        while (!ivalid && n < 10) begin
            step();
            n++;
        end
        check("boot_latency", n, 2);
        check("boot_iaddr", iaddr, 32'h0000_1000);
        fetch_ready = 1'b1;
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
